// File: rtl/digiclk_cpu_ocimem_arbiter_if.sv
// CPU monitor bus and OCI RAM port bundle seen by the ocimem arbiter.
// slave = arbiter side, master = CPU requester / RAM side.
interface digiclk_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/digiclk_cpu_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the JTAG debug path and the CPU monitor bus.
// Define DIGICLK_OCIMEM_CPU_PRIORITY_EN to give the CPU strict priority instead of round-robin.
module digiclk_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic [37:0]         jdo,
    input  logic                ovr_clr,
    digiclk_cpu_ocimem_arbiter_if.slave bus,
    output logic [31:0]         MonDReg,
    output logic [ADDR_W-1:0]   jtag_addr,
    output logic                jtag_busy,
    output logic                jtag_done,
    output logic                jtag_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_CPU,
        ACC_JTAG,
        RD_CPU,
        RD_JTAG
    } state_t;

    state_t      state;
    logic        pend_vld;
    logic        pend_we;
    logic [31:0] pend_wdata;
`ifndef DIGICLK_OCIMEM_CPU_PRIORITY_EN
    logic        last_grant_jtag;
`endif

    logic jtag_in_flight;
    logic jtag_strobe;
    logic jtag_capture;
    logic addr_load;
    logic new_overrun;
    logic cpu_want;
    logic grant_cpu;
    logic grant_jtag;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jtag_in_flight = (state == ACC_JTAG) || (state == RD_JTAG);
    assign jtag_busy      = pend_vld | jtag_in_flight;

    // A strobe needs a free slot; write wins a simultaneous write+read.
    always_comb begin
        jtag_strobe  = take_action_ocimem_b | take_no_action_ocimem_a;
        jtag_capture = jtag_strobe & ~jtag_busy;
        addr_load    = take_action_ocimem_a & ~jtag_busy;
        new_overrun  = (jtag_strobe & jtag_busy)
                     | (take_action_ocimem_b & take_no_action_ocimem_a)
                     | (take_action_ocimem_a & jtag_busy);
    end

    // The request is still high during its own ack cycle; do not serve it twice.
    always_comb begin
        cpu_want = bus.cpu_req & ~bus.cpu_ack;
`ifdef DIGICLK_OCIMEM_CPU_PRIORITY_EN
        grant_cpu  = cpu_want;
        grant_jtag = pend_vld & ~bus.cpu_req;
`else
        grant_cpu  = cpu_want & (~pend_vld | last_grant_jtag);
        grant_jtag = pend_vld & ~grant_cpu;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pend_vld      <= 1'b0;
            pend_we       <= 1'b0;
            pend_wdata    <= '0;
`ifndef DIGICLK_OCIMEM_CPU_PRIORITY_EN
            last_grant_jtag <= 1'b1;
`endif
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            MonDReg       <= '0;
            jtag_addr     <= '0;
            jtag_done     <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            bus.cpu_ack  <= 1'b0;
            jtag_done    <= 1'b0;
            jtag_overrun <= (jtag_overrun & ~ovr_clr) | new_overrun;

            // Load and capture only happen while idle, so the op sees the new address.
            if (addr_load)
                jtag_addr <= jdo[17 +: ADDR_W];
            if (jtag_capture) begin
                pend_vld   <= 1'b1;
                pend_we    <= take_action_ocimem_b;
                pend_wdata <= jdo[34:3];
            end

            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        state         <= ACC_CPU;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.cpu_we;
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= bus.cpu_wdata;
`ifndef DIGICLK_OCIMEM_CPU_PRIORITY_EN
                        last_grant_jtag <= 1'b0;
`endif
                    end else if (grant_jtag) begin
                        state         <= ACC_JTAG;
                        pend_vld      <= 1'b0;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= pend_we;
                        bus.mem_addr  <= jtag_addr;
                        bus.mem_wdata <= pend_wdata;
`ifndef DIGICLK_OCIMEM_CPU_PRIORITY_EN
                        last_grant_jtag <= 1'b1;
`endif
                    end
                end
                ACC_CPU: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    if (bus.mem_we) begin
                        bus.cpu_ack <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= RD_CPU;
                    end
                end
                RD_CPU: begin
                    bus.cpu_rdata <= bus.mem_rdata;
                    bus.cpu_ack   <= 1'b1;
                    state         <= IDLE;
                end
                ACC_JTAG: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    if (bus.mem_we) begin
                        MonDReg   <= bus.mem_wdata;
                        jtag_done <= 1'b1;
                        jtag_addr <= jtag_addr + ADDR_W'(1);
                        state     <= IDLE;
                    end else begin
                        state <= RD_JTAG;
                    end
                end
                RD_JTAG: begin
                    MonDReg   <= bus.mem_rdata;
                    jtag_done <= 1'b1;
                    jtag_addr <= jtag_addr + ADDR_W'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digiclk_cpu_ocimem_arbiter.sv
// Directed bench for the ocimem arbiter with a small behavioural RAM on the memory port.
module tb_digiclk_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        act_a, act_b, rd_a;
    logic [37:0] jdo;
    logic        ovr_clr;
    logic [31:0] mon;
    logic [7:0]  jaddr;
    logic        jbusy, jdone, jovr;

    int checks = 0;
    int errs   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr0, done0;

    digiclk_cpu_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

    digiclk_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (act_a),
        .take_action_ocimem_b    (act_b),
        .take_no_action_ocimem_a (rd_a),
        .jdo                     (jdo),
        .ovr_clr                 (ovr_clr),
        .bus                     (bus),
        .MonDReg                 (mon),
        .jtag_addr               (jaddr),
        .jtag_busy               (jbusy),
        .jtag_done               (jdone),
        .jtag_overrun            (jovr)
    );

    always #5 clk = ~clk;

    // RAM: contents A500_00xx after reset, one-cycle read latency.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    always @(posedge clk) if (jdone) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_addr(input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_wdata(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    initial begin
        reset = 1'b1; act_a = 0; act_b = 0; rd_a = 0; jdo = '0; ovr_clr = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst_ack", bus.cpu_ack, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mon", mon, 0);
        chk("rst_jaddr", jaddr, 0);
        chk("rst_busy", jbusy, 0);
        chk("rst_ovr", jovr, 0);

        // JTAG address load then write
        act_a = 1; jdo = mk_addr(8'h10);
        tick;
        chk("ld_addr", jaddr, 8'h10);
        act_a = 0; act_b = 1; jdo = mk_wdata(32'hDEADBEEF);
        tick;
        act_b = 0;
        chk("wr_busy", jbusy, 1);
        chk("wr_pre_en", bus.mem_en, 0);
        tick;
        chk("wr_en", bus.mem_en, 1);
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, 8'h10);
        chk("wr_data", bus.mem_wdata, 32'hDEADBEEF);
        chk("wr_done_early", jdone, 0);
        tick;
        chk("wr_done", jdone, 1);
        chk("wr_mon", mon, 32'hDEADBEEF);
        chk("wr_jaddr", jaddr, 8'h11);
        chk("wr_busy_end", jbusy, 0);
        chk("wr_en_end", bus.mem_en, 0);
        tick;
        chk("wr_done_pulse", jdone, 0);

        // CPU read of the word JTAG just wrote
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
        tick;
        chk("crd_ack0", bus.cpu_ack, 0);
        chk("crd_en", bus.mem_en, 1);
        chk("crd_we", bus.mem_we, 0);
        tick;
        chk("crd_ack1", bus.cpu_ack, 0);
        tick;
        chk("crd_ack2", bus.cpu_ack, 1);
        chk("crd_data", bus.cpu_rdata, 32'hDEADBEEF);
        chk("crd_nodone", jdone, 0);
        bus.cpu_req = 0;
        tick;
        chk("crd_ack_pulse", bus.cpu_ack, 0);
        chk("crd_hold", bus.cpu_rdata, 32'hDEADBEEF);

        // Arbitration from reset: CPU first, then JTAG, then CPU
        reset = 1; tick; reset = 0;
        rd_a = 1;
        tick;
        rd_a = 0; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h05;
        tick;
        chk("arb1_addr", bus.mem_addr, 8'h05);
        chk("arb1_busy", jbusy, 1);
        tick; tick;
        chk("arb1_ack", bus.cpu_ack, 1);
        chk("arb1_data", bus.cpu_rdata, 32'hA500_0005);
        bus.cpu_addr = 8'h06;
        tick;
        chk("arb2_en", bus.mem_en, 1);
        chk("arb2_addr", bus.mem_addr, 8'h00);
        chk("arb2_ack", bus.cpu_ack, 0);
        tick; tick;
        chk("arb2_done", jdone, 1);
        chk("arb2_mon", mon, 32'hA500_0000);
        chk("arb2_jaddr", jaddr, 8'h01);
        tick;
        chk("arb3_addr", bus.mem_addr, 8'h06);
        tick; tick;
        chk("arb3_ack", bus.cpu_ack, 1);
        chk("arb3_data", bus.cpu_rdata, 32'hA500_0006);
        bus.cpu_req = 0;
        tick;

        // Address wrap at all-ones
        act_a = 1; jdo = mk_addr(8'hFF);
        tick;
        act_a = 0; rd_a = 1;
        chk("wrap_ld", jaddr, 8'hFF);
        tick;
        rd_a = 0;
        tick;
        chk("wrap_addr", bus.mem_addr, 8'hFF);
        tick; tick;
        chk("wrap_done", jdone, 1);
        chk("wrap_mon", mon, 32'hA500_00FF);
        chk("wrap_jaddr", jaddr, 8'h00);
        tick;

        // Second write strobe while the first is pending
        wr0 = wr_cnt; done0 = done_cnt;
        act_b = 1; jdo = mk_wdata(32'h12345678);
        tick;
        jdo = mk_wdata(32'h0BADF00D);
        tick;
        act_b = 0;
        chk("ovr_set", jovr, 1);
        chk("ovr_wdata", bus.mem_wdata, 32'h12345678);
        tick;
        chk("ovr_mon", mon, 32'h12345678);
        tick; tick;
        chk("ovr_wr_cnt", 32'(wr_cnt - wr0), 1);
        chk("ovr_done_cnt", 32'(done_cnt - done0), 1);
        chk("ovr_sticky", jovr, 1);
        ovr_clr = 1;
        tick;
        ovr_clr = 0;
        chk("ovr_clr", jovr, 0);

        // Simultaneous write+read: write captured, overrun; new overrun beats ovr_clr
        act_b = 1; rd_a = 1; jdo = mk_wdata(32'hCAFEF00D);
        tick;
        act_b = 0;
        chk("wr_rd_ovr", jovr, 1);
        ovr_clr = 1;
        tick;
        rd_a = 0;
        chk("clr_lose", jovr, 1);
        chk("wr_rd_we", bus.mem_we, 1);
        tick;
        ovr_clr = 0;
        chk("clr_win", jovr, 0);
        chk("wr_rd_mon", mon, 32'hCAFEF00D);
        tick;

        // Address load together with write: op uses the new address
        act_a = 1; act_b = 1; jdo = mk_wdata(32'h0008_4000);
        tick;
        act_a = 0; act_b = 0;
        chk("ldop_jaddr", jaddr, 8'h21);
        tick;
        chk("ldop_addr", bus.mem_addr, 8'h21);
        chk("ldop_wdata", bus.mem_wdata, 32'h0008_4000);
        tick;
        chk("ldop_inc", jaddr, 8'h22);
        tick;

        // Reset while a JTAG read is in ACC_JTAG
        rd_a = 1;
        tick;
        rd_a = 0;
        tick;
        chk("abort_en", bus.mem_en, 1);
        reset = 1;
        tick;
        reset = 0;
        chk("abort_done", jdone, 0);
        chk("abort_mon", mon, 0);
        chk("abort_busy", jbusy, 0);
        chk("abort_en_off", bus.mem_en, 0);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 32'h0000_0077;
        tick;
        chk("abort_nodone", jdone, 0);
        chk("post_cwr_en", bus.mem_en, 1);
        chk("post_cwr_addr", bus.mem_addr, 8'h20);
        tick;
        chk("post_cwr_ack", bus.cpu_ack, 1);
        bus.cpu_req = 0;
        tick;
        chk("post_cwr_ack_pulse", bus.cpu_ack, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
